// File: rtl/fec_dec_rx_filter.sv
// rtl/fec_dec_rx_filter.sv - FEC decoder receive filter: parses Ethernet/FEC headers and forwards accepted payload
module fec_dec_rx_filter #(
    parameter logic [15:0] g_fec_ethertype = 16'h0800,
    parameter int          g_max_words     = 760
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_sel_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [15:0] snk_dat_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [1:0]  src_sel_o,
    output logic [1:0]  src_adr_o,
    output logic [15:0] src_dat_o,
    input  logic        src_stall_i,
    input  logic        src_ack_i,
    input  logic        cfg_en_i,
    input  logic [47:0] cfg_mac_i,
    output logic        hdr_valid_o,
    output logic [15:0] hdr_fec_id_o,
    output logic [3:0]  hdr_frag_o,
    output logic [11:0] hdr_len_o,
    output logic [31:0] rx_cnt_o,
    output logic [31:0] drp_cnt_o,
    output logic [31:0] err_cnt_o
);

    localparam int CW = $clog2(g_max_words + 1);

    typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

    state_t        state, state_nx;
    logic          cyc_q;
    logic [3:0]    k;
    logic          mac_ok, bc_ok;
    logic [15:0]   fec_id_q;
    logic [CW-1:0] pay_cnt;
    logic          err_flag;
    logic          take, data_word, sof, hdr_word, hdr_drop, hdr_done, fwd_end, err_inc;
    logic [15:0]   mac_word;
    logic          unused_ok;

    assign unused_ok = &{1'b0, snk_we_i, src_ack_i};
    assign src_adr_o = 2'b00;

    assign take      = snk_cyc_i & snk_stb_i & ~snk_stall_o;
    assign data_word = take & (snk_adr_i == 2'b00);
    assign sof       = snk_cyc_i & ~cyc_q;
    // A word arriving together with the rising cyc is already header word 0.
    assign hdr_word  = data_word & ((state == HDR) | ((state == IDLE) & sof));
    assign mac_word  = (k == 4'd0) ? cfg_mac_i[47:32] :
                       (k == 4'd1) ? cfg_mac_i[31:16] : cfg_mac_i[15:0];
    assign hdr_drop  = hdr_word & (k == 4'd6) &
                       (~(mac_ok | bc_ok) | ~cfg_en_i | (snk_dat_i != g_fec_ethertype));
    assign hdr_done  = hdr_word & (k == 4'd8);
    assign fwd_end   = (state == FWD) & ~snk_cyc_i & ~(src_stb_o & src_stall_i);
    assign err_inc   = ((state == HDR) & ~snk_cyc_i) | (fwd_end & err_flag);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        snk_stall_o = 1'b0;
        case (state)
            IDLE: if (sof) state_nx = HDR;
            HDR: begin
                if (!snk_cyc_i)    state_nx = IDLE;
                else if (hdr_drop) state_nx = DROP;
                else if (hdr_done) state_nx = FWD;
            end
            FWD: begin
                snk_stall_o = src_stall_i;
                if (fwd_end) state_nx = IDLE;
            end
            DROP: if (!snk_cyc_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cyc_q        <= 1'b0;
            snk_ack_o    <= 1'b0;
            k            <= '0;
            mac_ok       <= 1'b0;
            bc_ok        <= 1'b0;
            fec_id_q     <= '0;
            pay_cnt      <= '0;
            err_flag     <= 1'b0;
            src_cyc_o    <= 1'b0;
            src_stb_o    <= 1'b0;
            src_we_o     <= 1'b0;
            src_sel_o    <= '0;
            src_dat_o    <= '0;
            hdr_valid_o  <= 1'b0;
            hdr_fec_id_o <= '0;
            hdr_frag_o   <= '0;
            hdr_len_o    <= '0;
            rx_cnt_o     <= '0;
            drp_cnt_o    <= '0;
            err_cnt_o    <= '0;
        end else begin
            cyc_q       <= snk_cyc_i;
            snk_ack_o   <= take;
            hdr_valid_o <= 1'b0;

            if (hdr_word)           k <= k + 4'd1;
            else if (state != HDR)  k <= '0;

            if (hdr_word && k <= 4'd2) begin
                mac_ok <= ((k == 4'd0) | mac_ok) & (snk_dat_i == mac_word);
                bc_ok  <= ((k == 4'd0) | bc_ok) & (snk_dat_i == 16'hffff);
            end
            if (hdr_word && k == 4'd7) fec_id_q <= snk_dat_i;

            if (hdr_done) begin
                hdr_fec_id_o <= fec_id_q;
                hdr_frag_o   <= snk_dat_i[15:12];
                hdr_len_o    <= snk_dat_i[11:0];
                hdr_valid_o  <= 1'b1;
                src_cyc_o    <= 1'b1;
                src_we_o     <= 1'b1;
                pay_cnt      <= '0;
                err_flag     <= 1'b0;
            end

            if (state == FWD) begin
                // A word is only taken from the sink while the source is not stalled.
                if (data_word && pay_cnt < CW'(g_max_words)) begin
                    src_stb_o <= 1'b1;
                    src_dat_o <= snk_dat_i;
                    src_sel_o <= snk_sel_i;
                    pay_cnt   <= pay_cnt + 1'b1;
                end else if (!src_stall_i) begin
                    src_stb_o <= 1'b0;
                end
                if (take && snk_adr_i == 2'b10 && snk_dat_i[1]) err_flag <= 1'b1;
                if (fwd_end) begin
                    src_cyc_o <= 1'b0;
                    src_we_o  <= 1'b0;
                    src_stb_o <= 1'b0;
                    if (!err_flag) rx_cnt_o <= rx_cnt_o + 32'd1;
                end
            end

            if (err_inc)                      err_cnt_o <= err_cnt_o + 32'd1;
            if (state == DROP && !snk_cyc_i)  drp_cnt_o <= drp_cnt_o + 32'd1;
        end
    end

endmodule
